// File: rtl/out_port_fifo_if.sv
// Signal bundle between the core's OUT write-back path, the output FIFO and its consumer.
// The FIFO takes the slave modport; the driver of writes and pops takes master.
interface out_port_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             out_wr;
    logic [WIDTH-1:0] out_data;
    logic             out_full;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last_out;
    logic             ovf;
    logic             ovf_clr;

    modport slave (
        input  out_wr, out_data, dout_ready, ovf_clr,
        output out_full, dout, dout_valid, count, last_out, ovf
    );

    modport master (
        output out_wr, out_data, dout_ready, ovf_clr,
        input  out_full, dout, dout_valid, count, last_out, ovf
    );
endinterface

// File: rtl/out_port_fifo.sv
// Show-ahead output-port FIFO: queues OUT words from the core and drains them over valid/ready.
// Writes into a full queue are accepted only when a pop frees a slot in the same cycle.
module out_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    out_port_fifo_if.slave        bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] last_out_q, last_out_d;
    logic             ovf_q, ovf_d;

    logic full, empty, pop, push, drop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.dout_ready;
    assign push  = bus.out_wr && (!full || pop);
    assign drop  = bus.out_wr && full && !pop;

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        last_out_d = last_out_q;
        ovf_d      = ovf_q;
        if (push) begin
            wp_d       = wp_q + 1'b1;
            last_out_d = bus.out_data;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            last_out_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            last_out_q <= last_out_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are masked by dout_valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wp_q == AW'(gi))) begin
                mem_q[gi] <= bus.out_data;
            end
        end
    end

    assign bus.dout       = mem_q[rp_q];
    assign bus.dout_valid = !empty;
    assign bus.out_full   = full;
    assign bus.count      = count_q;
    assign bus.last_out   = last_out_q;
    assign bus.ovf        = ovf_q;
endmodule
